// File: rtl/dcim_oai_mac.sv
// dcim_oai_mac: bit-serial multi-channel MAC built on the OAI partial-product cell.
// Each lane holds a captured weight and streams its activation LSB-first, one bit
// per clock. Partial products are shifted and accumulated per lane. The top level
// sequences IDLE/RUN/DONE and registers the per-lane results and their sum.

module dcim_oai_lane #(
  parameter int WIDTH = 12,
  parameter int XBITS = 8,
  parameter int ACC_W = WIDTH + XBITS,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] w_i,
  input  logic [XBITS-1:0] x_i,
  input  logic             en_i,
  input  logic             c_i,
  input  logic             d_i,
  input  logic [CNT_W-1:0] bit_idx_i,
  output logic [ACC_W-1:0] acc_d_o
);

  logic [WIDTH-1:0] w_q;
  logic [XBITS-1:0] x_q;
  logic             en_q;
  logic [ACC_W-1:0] acc_q;
  logic [WIDTH-1:0] e, pp;

  // OAI cell output, inverted back to a partial product, shifted into the accumulator
  always_comb begin
    e       = ~((w_q | {WIDTH{c_i}}) & ({WIDTH{x_q[0]}} | {WIDTH{d_i}}));
    pp      = ~e;
    acc_d_o = en_q ? acc_q + (ACC_W'(pp) << bit_idx_i) : '0;
  end

  // Operand capture on accept; activation shifts right so bit 0 is always the live bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q   <= '0;
      x_q   <= '0;
      en_q  <= 1'b0;
      acc_q <= '0;
    end else if (load_i) begin
      w_q   <= w_i;
      x_q   <= x_i;
      en_q  <= en_i;
      acc_q <= '0;
    end else if (step_i) begin
      x_q   <= x_q >> 1;
      acc_q <= acc_d_o;
    end
  end

endmodule

module dcim_oai_mac #(
  parameter int WIDTH = 12,
  parameter int XBITS = 8,
  parameter int CH    = 4,
  parameter int ACC_W = WIDTH + XBITS,
  parameter int SUM_W = ACC_W + $clog2(CH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [CH*WIDTH-1:0] w_in,
  input  logic [CH*XBITS-1:0] x_in,
  input  logic [1:0]          mode,
  input  logic [CH-1:0]       ch_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*ACC_W-1:0] out_data,
  output logic [SUM_W-1:0]    out_sum,
  output logic                busy
);

  localparam int CNT_W = (XBITS > 1) ? $clog2(XBITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state_q, state_d;
  logic   [CNT_W-1:0]           cnt_q;
  logic   [1:0]                 mode_q;
  logic   [CH-1:0][ACC_W-1:0]   acc_d;
  logic   [SUM_W-1:0]           sum_d;
  logic   [CH*ACC_W-1:0]        out_data_q;
  logic   [SUM_W-1:0]           out_sum_q;
  logic                         accept, last_bit;

  assign start_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept      = start_valid && start_ready;
  assign last_bit    = (cnt_q == CNT_W'(XBITS - 1));
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == RUN);
  assign out_data    = out_data_q;
  assign out_sum     = out_sum_q;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    dcim_oai_lane #(
      .WIDTH (WIDTH),
      .XBITS (XBITS),
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (accept),
      .step_i    (busy),
      .w_i       (w_in[k*WIDTH +: WIDTH]),
      .x_i       (x_in[k*XBITS +: XBITS]),
      .en_i      (ch_en[k]),
      .c_i       (mode_q[1]),
      .d_i       (mode_q[0]),
      .bit_idx_i (cnt_q),
      .acc_d_o   (acc_d[k])
    );
  end

  // Cross-channel sum of the lanes' next accumulator values (disabled lanes give 0)
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < CH; k++) sum_d = sum_d + SUM_W'(acc_d[k]);
  end

  // Next-state logic; DONE may hand straight back to RUN when a new request waits
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = start_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, bit counter, mode capture and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_q     <= '0;
      out_data_q <= '0;
      out_sum_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q  <= '0;
        mode_q <= mode;
      end else if (busy) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (busy && last_bit) begin
        out_data_q <= acc_d;
        out_sum_q  <= sum_d;
      end
    end
  end

endmodule
